fx3_stream_arbiter: RTL and testbench

Burst scheduler that shares the FX3 slave-FIFO write port between two sample sources: raw ADC samples (source 0) and FFT result words (source 1). It picks one source per burst with round-robin arbitration and only starts a burst when that source's FX3 socket flag reports space. It then drives `faddr`, `fdata`, `slwr_n` and `pkt_end_n` for the whole burst. It sits between the ADC/FFT output FIFOs and the FX3 GPIF pins, and replaces the fixed-address single-stream write control.

---
 rtl/fx3_stream_arbiter.sv | 167 ++++++++++++++++
 tb/tb_fx3_stream_arbiter.sv | 433 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fx3_stream_arbiter.sv
// Round-robin burst scheduler sharing the FX3 slave-FIFO write port between
// the ADC sample stream (source 0) and the FFT result stream (source 1).
module fx3_stream_arbiter #(
  parameter int unsigned BURST_LEN = 512,
  parameter int unsigned GAP_CYC   = 3,
  parameter logic [1:0]  ADDR0     = 2'b10,
  parameter logic [1:0]  ADDR1     = 2'b11
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        s0_req,
  input  logic        s0_empty,
  input  logic [11:0] s0_data,
  input  logic        s0_eof,
  output logic        s0_rd,
  input  logic        s1_req,
  input  logic        s1_empty,
  input  logic [15:0] s1_data,
  input  logic        s1_eof,
  output logic        s1_rd,
  input  logic        flagd,
  input  logic        flagb,
  output logic [15:0] fdata,
  output logic [1:0]  faddr,
  output logic        slwr_n,
  output logic        pkt_end_n,
  output logic        slrd_n,
  output logic        sloe_n,
  output logic        busy,
  output logic        underrun,
  output logic [15:0] burst_cnt
);

  localparam int unsigned CntW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [CntW-1:0] LastIdx = CntW'(BURST_LEN - 1);
  localparam logic [3:0] GapLast = 4'(GAP_CYC - 1);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StAddr  = 2'd1;
  localparam logic [1:0] StWrite = 2'd2;
  localparam logic [1:0] StGap   = 2'd3;

  logic [1:0]      state_q, state_d;
  logic            grant_q, grant_d;   // 1 = source 1 owns the burst
  logic            last_q, last_d;
  logic [CntW-1:0] word_cnt_q, word_cnt_d;
  logic [3:0]      gap_cnt_q, gap_cnt_d;
  logic [1:0]      faddr_q, faddr_d;
  logic [15:0]     fdata_q, fdata_d;
  logic            slwr_n_q, slwr_n_d;
  logic            pkt_end_n_q, pkt_end_n_d;
  logic            underrun_q, underrun_d;
  logic [15:0]     burst_cnt_q, burst_cnt_d;

  logic        elig0, elig1, pick;
  logic        src_empty, src_eof, rd_ok;
  logic [15:0] src_word;

  assign elig0 = enable & s0_req & flagd;
  assign elig1 = enable & s1_req & flagb;

  // Mux the granted source's FWFT head onto a common 16-bit word.
  assign src_empty = grant_q ? s1_empty : s0_empty;
  assign src_eof   = grant_q ? s1_eof : s0_eof;
  assign src_word  = grant_q ? s1_data : {4'b0000, s0_data};

  assign rd_ok = (state_q == StWrite) & ~src_empty;
  assign s0_rd = rd_ok & ~grant_q;
  assign s1_rd = rd_ok & grant_q;

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    last_d      = last_q;
    word_cnt_d  = word_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    faddr_d     = faddr_q;
    fdata_d     = fdata_q;
    slwr_n_d    = 1'b1;
    pkt_end_n_d = 1'b1;
    underrun_d  = underrun_q;
    burst_cnt_d = burst_cnt_q;
    pick        = 1'b0;

    case (state_q)
      StIdle: begin
        if (elig0 | elig1) begin
          // On a tie the source that did not own the previous burst wins.
          pick    = (elig0 & elig1) ? ~last_q : elig1;
          grant_d = pick;
          faddr_d = pick ? ADDR1 : ADDR0;
          state_d = StAddr;
        end
      end
      StAddr: begin
        word_cnt_d = '0;
        state_d    = StWrite;
      end
      StWrite: begin
        if (src_empty) begin
          underrun_d = 1'b1;
          gap_cnt_d  = '0;
          state_d    = StGap;
        end else begin
          fdata_d     = src_word;
          slwr_n_d    = 1'b0;
          pkt_end_n_d = ~src_eof;
          word_cnt_d  = word_cnt_q + CntW'(1);
          if ((word_cnt_q == LastIdx) || src_eof) begin
            burst_cnt_d = burst_cnt_q + 16'd1;
            gap_cnt_d   = '0;
            state_d     = StGap;
          end
        end
      end
      StGap: begin
        if (gap_cnt_q == GapLast) begin
          last_d  = grant_q;
          state_d = StIdle;
        end else begin
          gap_cnt_d = gap_cnt_q + 4'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      grant_q     <= 1'b0;
      last_q      <= 1'b1;
      word_cnt_q  <= '0;
      gap_cnt_q   <= '0;
      faddr_q     <= ADDR0;
      fdata_q     <= '0;
      slwr_n_q    <= 1'b1;
      pkt_end_n_q <= 1'b1;
      underrun_q  <= 1'b0;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      last_q      <= last_d;
      word_cnt_q  <= word_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      faddr_q     <= faddr_d;
      fdata_q     <= fdata_d;
      slwr_n_q    <= slwr_n_d;
      pkt_end_n_q <= pkt_end_n_d;
      underrun_q  <= underrun_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  assign fdata     = fdata_q;
  assign faddr     = faddr_q;
  assign slwr_n    = slwr_n_q;
  assign pkt_end_n = pkt_end_n_q;
  assign slrd_n    = 1'b1;
  assign sloe_n    = 1'b1;
  assign busy      = (state_q != StIdle);
  assign underrun  = underrun_q;
  assign burst_cnt = burst_cnt_q;

endmodule

// File: tb/tb_fx3_stream_arbiter.sv
// Bench for fx3_stream_arbiter: queue-based FWFT sources and a transaction-level
// burst model that predicts every FX3 write (address, pkt_end, data).
module tb_fx3_stream_arbiter;

  localparam int unsigned BL = 8;
  localparam int unsigned GC = 3;
  localparam logic [1:0]  A0 = 2'b10;
  localparam logic [1:0]  A1 = 2'b11;

  logic clk = 1'b0;
  logic reset_n;
  logic enable, flagd, flagb;
  logic s0_req, s0_empty, s0_eof, s0_rd;
  logic s1_req, s1_empty, s1_eof, s1_rd;
  logic [11:0] s0_data;
  logic [15:0] s1_data, fdata, burst_cnt;
  logic [1:0] faddr;
  logic slwr_n, pkt_end_n, slrd_n, sloe_n, busy, underrun;

  always #5 clk = ~clk;

  fx3_stream_arbiter #(.BURST_LEN(BL), .GAP_CYC(GC), .ADDR0(A0), .ADDR1(A1)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .s0_req(s0_req), .s0_empty(s0_empty), .s0_data(s0_data), .s0_eof(s0_eof), .s0_rd(s0_rd),
    .s1_req(s1_req), .s1_empty(s1_empty), .s1_data(s1_data), .s1_eof(s1_eof), .s1_rd(s1_rd),
    .flagd(flagd), .flagb(flagb), .fdata(fdata), .faddr(faddr), .slwr_n(slwr_n),
    .pkt_end_n(pkt_end_n), .slrd_n(slrd_n), .sloe_n(sloe_n), .busy(busy),
    .underrun(underrun), .burst_cnt(burst_cnt)
  );

  // Source FIFOs: entries are {eof, data[15:0]}.
  logic [16:0] src0[$], src1[$];
  logic [16:0] m0[$], m1[$];
  logic [18:0] exp_q[$], got[$];   // {faddr, pkt_end_n, fdata}
  int          wr_cyc[$];
  logic        mlast;
  logic [15:0] exp_bcnt;
  int          n_cmp = 0, n_fail = 0;

  int          sz0, sz1, cyc, rd_cnt0, rd_cnt1, stray_pkt;
  logic [16:0] head0, head1;
  logic        eofin0, eofin1, pop0, pop1, force_empty0;

  assign s0_empty = force_empty0 || (sz0 == 0);
  assign s1_empty = (sz1 == 0);
  assign s0_data  = head0[11:0];
  assign s1_data  = head1[15:0];
  assign s0_eof   = head0[16] && (sz0 != 0);
  assign s1_eof   = head1[16] && (sz1 != 0);
  assign s0_req   = (sz0 >= BL) || eofin0;
  assign s1_req   = (sz1 >= BL) || eofin1;

  function automatic logic q_has_eof(input logic [16:0] q[$]);
    foreach (q[i]) if (q[i][16]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic q_req(input logic [16:0] q[$]);
    return (q.size() >= BL) || q_has_eof(q);
  endfunction

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    pop0    <= s0_rd;
    pop1    <= s1_rd;
    rd_cnt0 <= rd_cnt0 + (s0_rd ? 1 : 0);
    rd_cnt1 <= rd_cnt1 + (s1_rd ? 1 : 0);
  end

  // Consume popped words, log FX3 writes, then present the new FIFO heads.
  always @(negedge clk) begin
    if (pop0 === 1'b1 && src0.size() > 0) void'(src0.pop_front());
    if (pop1 === 1'b1 && src1.size() > 0) void'(src1.pop_front());
    if (reset_n === 1'b1 && slwr_n === 1'b0) begin
      got.push_back({faddr, pkt_end_n, fdata});
      wr_cyc.push_back(cyc);
    end
    if (pkt_end_n === 1'b0 && slwr_n !== 1'b0) stray_pkt <= stray_pkt + 1;
    sz0    <= src0.size();
    sz1    <= src1.size();
    head0  <= (src0.size() > 0) ? src0[0] : 17'h0;
    head1  <= (src1.size() > 0) ? src1[0] : 17'h0;
    eofin0 <= q_has_eof(src0);
    eofin1 <= q_has_eof(src1);
  end

  function automatic void push_word(input bit src, input logic eof, input logic [15:0] d);
    if (!src) begin
      src0.push_back({eof, 4'b0000, d[11:0]});
      m0.push_back({eof, 4'b0000, d[11:0]});
    end else begin
      src1.push_back({eof, d});
      m1.push_back({eof, d});
    end
  endfunction

  // Burst-level model: grant by round robin among eligible sources, take words until
  // BURST_LEN or an eof word.
  function automatic void run_model(input logic fd, input logic fb, input logic en,
                                    input int max_bursts);
    for (int b = 0; b < max_bursts; b++) begin
      logic e0, e1, p;
      logic [16:0] w;
      e0 = en && fd && q_req(m0);
      e1 = en && fb && q_req(m1);
      if (!e0 && !e1) break;
      p = (e0 && e1) ? !mlast : e1;
      for (int n = 0; n < BL; n++) begin
        w = p ? m1.pop_front() : m0.pop_front();
        exp_q.push_back({p ? A1 : A0, !w[16], p ? w[15:0] : {4'b0000, w[11:0]}});
        if (w[16]) break;
      end
      mlast    = p;
      exp_bcnt = exp_bcnt + 16'd1;
    end
  endfunction

  function automatic void clear_all();
    src0.delete(); src1.delete(); m0.delete(); m1.delete();
    exp_q.delete(); got.delete(); wr_cyc.delete();
  endfunction

  task automatic wait_idle(input string tag);
    int idle = 0;
    int c = 0;
    while (idle < 12 && c < 3000) begin
      @(negedge clk);
      c++;
      idle = (busy === 1'b0) ? idle + 1 : 0;
    end
    n_cmp++;
    if (idle < 12) begin
      n_fail++;
      $display("FAIL %s_drain: observed busy for %0d cycles, required idle", tag, c);
    end
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    reset_n = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    clear_all();
    force_empty0 = 1'b0;
    mlast = 1'b1;
    exp_bcnt = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; enable = 1'b1; flagd = 1'b0; flagb = 1'b0; force_empty0 = 1'b0;
    mlast = 1'b1; exp_bcnt = '0;
    repeat (3) @(negedge clk);
    n_cmp += 6;
    if (fdata !== 16'h0) begin n_fail++; $display("FAIL rst_fdata: observed %h, required 0", fdata); end
    if (faddr !== A0) begin n_fail++; $display("FAIL rst_faddr: observed %b, required %b", faddr, A0); end
    if ({slwr_n, pkt_end_n, slrd_n, sloe_n} !== 4'b1111) begin
      n_fail++; $display("FAIL rst_strobes: observed %b, required 1111", {slwr_n, pkt_end_n, slrd_n, sloe_n});
    end
    if ({s0_rd, s1_rd, busy, underrun} !== 4'b0000) begin
      n_fail++; $display("FAIL rst_flags: observed %b, required 0000", {s0_rd, s1_rd, busy, underrun});
    end
    if (burst_cnt !== 16'h0) begin n_fail++; $display("FAIL rst_bcnt: observed %0d, required 0", burst_cnt); end
    if (dut.last_q !== 1'b1) begin n_fail++; $display("FAIL rst_last: observed %b, required 1", dut.last_q); end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_single_source();
    int t0;
    @(posedge clk); #2;
    flagd = 1'b1; flagb = 1'b1;
    for (int i = 0; i < 8; i++) push_word(1'b0, 1'b0, 16'(i));
    run_model(1'b1, 1'b1, 1'b1, 100);
    @(negedge clk);
    t0 = cyc;
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b1 || faddr !== A0) begin
      n_fail++; $display("FAIL single_grant: observed busy=%b faddr=%b, required 1/%b", busy, faddr, A0);
    end
    wait_idle("single");
    n_cmp += 2;
    if (got.size() !== exp_q.size()) begin
      n_fail++; $display("FAIL single_count: observed %0d, required %0d", got.size(), exp_q.size());
    end
    if (burst_cnt !== exp_bcnt) begin
      n_fail++; $display("FAIL single_bcnt: observed %0d, required %0d", burst_cnt, exp_bcnt);
    end
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      n_cmp += 2;
      if (got[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL single_word[%0d]: observed %h, required %h", i, got[i], exp_q[i]);
      end
      if (wr_cyc[i] !== t0 + 3 + i) begin
        n_fail++; $display("FAIL single_timing[%0d]: observed cycle %0d, required %0d", i, wr_cyc[i], t0 + 3 + i);
      end
    end
  endtask

  task automatic test_round_robin();
    apply_reset();
    @(posedge clk); #2;
    flagd = 1'b1; flagb = 1'b1;
    for (int i = 0; i < 16; i++) begin
      push_word(1'b0, 1'b0, 16'($urandom_range(0, 4095)));
      push_word(1'b1, 1'b0, 16'($urandom));
    end
    run_model(1'b1, 1'b1, 1'b1, 100);
    wait_idle("rr");
    n_cmp += 2;
    if (got.size() !== exp_q.size()) begin
      n_fail++; $display("FAIL rr_count: observed %0d, required %0d", got.size(), exp_q.size());
    end
    if (burst_cnt !== exp_bcnt) begin
      n_fail++; $display("FAIL rr_bcnt: observed %0d, required %0d", burst_cnt, exp_bcnt);
    end
    if (got.size() > 8) begin
      n_cmp++;
      if (got[0][18:17] !== A0 || got[8][18:17] !== A1) begin
        n_fail++; $display("FAIL rr_order: observed %b,%b, required %b,%b", got[0][18:17], got[8][18:17], A0, A1);
      end
    end
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      n_cmp++;
      if (got[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL rr_word[%0d]: observed %h, required %h", i, got[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_eof_frame();
    int rd_base;
    @(posedge clk); #1;
    clear_all();
    rd_base = rd_cnt1;
    #1;
    for (int i = 0; i < 5; i++) push_word(1'b1, i == 4, 16'hA000 + 16'(i));
    run_model(1'b1, 1'b1, 1'b1, 100);
    wait_idle("eof");
    n_cmp += 3;
    if (got.size() !== exp_q.size()) begin
      n_fail++; $display("FAIL eof_count: observed %0d, required %0d", got.size(), exp_q.size());
    end
    if (rd_cnt1 - rd_base !== 5) begin
      n_fail++; $display("FAIL eof_rd: observed %0d, required 5", rd_cnt1 - rd_base);
    end
    if (burst_cnt !== exp_bcnt) begin
      n_fail++; $display("FAIL eof_bcnt: observed %0d, required %0d", burst_cnt, exp_bcnt);
    end
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      n_cmp++;
      if (got[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL eof_word[%0d]: observed %h, required %h", i, got[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_flag_gate();
    int c = 0;
    @(posedge clk); #1;
    clear_all();
    #1;
    flagd = 1'b0; flagb = 1'b1;
    for (int i = 0; i < 8; i++) push_word(1'b0, 1'b0, 16'h100 + 16'(i));
    for (int i = 0; i < 24; i++) push_word(1'b1, 1'b0, 16'h5500 + 16'(i));
    run_model(1'b0, 1'b1, 1'b1, 1);
    while (got.size() < 8 && c < 200) begin @(negedge clk); c++; end
    flagd = 1'b1;
    run_model(1'b1, 1'b1, 1'b1, 100);
    wait_idle("flag");
    n_cmp += 2;
    if (got.size() !== exp_q.size()) begin
      n_fail++; $display("FAIL flag_count: observed %0d, required %0d", got.size(), exp_q.size());
    end
    if (got.size() > 8 && got[8][18:17] !== A0) begin
      n_fail++; $display("FAIL flag_second_grant: observed %b, required %b", got[8][18:17], A0);
    end
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      n_cmp++;
      if (got[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL flag_word[%0d]: observed %h, required %h", i, got[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_underrun();
    int rd_base;
    int c = 0;
    @(posedge clk); #1;
    clear_all();
    rd_base = rd_cnt0;
    #1;
    for (int i = 0; i < 8; i++) push_word(1'b0, 1'b0, 16'h0C0 + 16'(i));
    for (int i = 0; i < 3; i++) exp_q.push_back({A0, 1'b1, 16'h00C0 + 16'(i)});
    while (rd_cnt0 - rd_base < 3 && c < 100) begin @(posedge clk); #1; c++; end
    force_empty0 = 1'b1;
    wait_idle("underrun");
    force_empty0 = 1'b0;
    mlast = 1'b0;
    n_cmp += 4;
    if (got.size() !== exp_q.size()) begin
      n_fail++; $display("FAIL underrun_count: observed %0d, required %0d", got.size(), exp_q.size());
    end
    if (rd_cnt0 - rd_base !== 3) begin
      n_fail++; $display("FAIL underrun_rd: observed %0d, required 3", rd_cnt0 - rd_base);
    end
    if (underrun !== 1'b1) begin n_fail++; $display("FAIL underrun_flag: observed %b, required 1", underrun); end
    if (burst_cnt !== exp_bcnt) begin
      n_fail++; $display("FAIL underrun_bcnt: observed %0d, required %0d", burst_cnt, exp_bcnt);
    end
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      n_cmp++;
      if (got[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL underrun_word[%0d]: observed %h, required %h", i, got[i], exp_q[i]);
      end
    end
    repeat (20) @(negedge clk);
    n_cmp++;
    if (underrun !== 1'b1) begin n_fail++; $display("FAIL underrun_sticky: observed %b, required 1", underrun); end
    @(posedge clk); #1;
    clear_all();
  endtask

  task automatic test_random();
    for (int it = 0; it < 4; it++) begin
      logic fd, fb, en;
      @(posedge clk); #1;
      clear_all();
      #1;
      fd = 1'($urandom_range(0, 1)); fb = 1'($urandom_range(0, 1));
      en = ($urandom_range(0, 3) != 0);
      if (it == 0) begin fd = 1'b1; fb = 1'b1; en = 1'b1; end
      flagd = fd; flagb = fb; enable = en;
      for (int s = 0; s < 2; s++) begin
        int nf = $urandom_range(1, 4);
        for (int f = 0; f < nf; f++) begin
          int len = $urandom_range(1, 20);
          for (int w = 0; w < len; w++) push_word(s[0], w == len - 1, 16'($urandom));
        end
      end
      run_model(fd, fb, en, 1000);
      wait_idle("rand");
      n_cmp += 2;
      if (got.size() !== exp_q.size()) begin
        n_fail++; $display("FAIL rand%0d_count: observed %0d, required %0d", it, got.size(), exp_q.size());
      end
      if (burst_cnt !== exp_bcnt) begin
        n_fail++; $display("FAIL rand%0d_bcnt: observed %0d, required %0d", it, burst_cnt, exp_bcnt);
      end
      for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
        n_cmp++;
        if (got[i] !== exp_q[i]) begin
          n_fail++; $display("FAIL rand%0d_word[%0d]: observed %h, required %h", it, i, got[i], exp_q[i]);
        end
      end
    end
    @(posedge clk); #1;
    clear_all();
    enable = 1'b1;
  endtask

  task automatic test_reset_mid_burst();
    int c = 0;
    @(posedge clk); #2;
    flagd = 1'b1; flagb = 1'b1;
    for (int i = 0; i < 8; i++) push_word(1'b0, 1'b0, 16'h300 + 16'(i));
    while (got.size() < 3 && c < 100) begin @(negedge clk); c++; end
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    n_cmp += 3;
    if (slwr_n !== 1'b1 || pkt_end_n !== 1'b1) begin
      n_fail++; $display("FAIL midrst_strobe: observed %b%b, required 11", slwr_n, pkt_end_n);
    end
    if (busy !== 1'b0 || underrun !== 1'b0 || s0_rd !== 1'b0) begin
      n_fail++; $display("FAIL midrst_state: observed %b%b%b, required 000", busy, underrun, s0_rd);
    end
    if (burst_cnt !== 16'h0) begin n_fail++; $display("FAIL midrst_bcnt: observed %0d, required 0", burst_cnt); end
    @(negedge clk);
    @(posedge clk); #1;
    clear_all();
    mlast = 1'b1; exp_bcnt = '0;
    for (int i = 0; i < 8; i++) begin
      push_word(1'b1, 1'b0, 16'h7700 + 16'(i));
      push_word(1'b0, 1'b0, 16'h400 + 16'(i));
    end
    run_model(1'b1, 1'b1, 1'b1, 100);
    @(negedge clk);
    reset_n = 1'b1;
    wait_idle("midrst");
    n_cmp += 2;
    if (got.size() !== exp_q.size()) begin
      n_fail++; $display("FAIL midrst_count: observed %0d, required %0d", got.size(), exp_q.size());
    end
    if (got.size() > 0 && got[0][18:17] !== A0) begin
      n_fail++; $display("FAIL midrst_first_grant: observed %b, required %b", got[0][18:17], A0);
    end
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      n_cmp++;
      if (got[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL midrst_word[%0d]: observed %h, required %h", i, got[i], exp_q[i]);
      end
    end
  endtask

  initial begin
    cyc = 0; rd_cnt0 = 0; rd_cnt1 = 0; stray_pkt = 0; sz0 = 0; sz1 = 0;
    test_reset();
    test_single_source();
    test_round_robin();
    test_eof_frame();
    test_flag_gate();
    test_underrun();
    test_random();
    test_reset_mid_burst();
    n_cmp++;
    if (stray_pkt !== 0) begin
      n_fail++; $display("FAIL pkt_end_alone: observed %0d cycles, required 0", stray_pkt);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
